// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared types, constants and helpers for the set-associative
//               branch target buffer (index/tag extraction, confidence
//               counter encoding, flush FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    localparam int BTB_ADDR_W = 32;
    // Widest PC the index/tag helpers accept; callers zero-extend into it.
    localparam int BTB_MAX_W  = 64;

    localparam logic [1:0] CTR_INIT = 2'd2;
    localparam logic [1:0] CTR_MAX  = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    // Set index: word-aligned PC bits directly above the byte offset.
    function automatic logic [BTB_MAX_W-1:0] btb_index(input logic [BTB_MAX_W-1:0] pc,
                                                       input int set_w);
        return (pc >> 2) & ((BTB_MAX_W'(1) << set_w) - BTB_MAX_W'(1));
    endfunction

    // Tag: everything above the index; caller truncates to its tag width.
    function automatic logic [BTB_MAX_W-1:0] btb_tag(input logic [BTB_MAX_W-1:0] pc,
                                                     input int set_w);
        return pc >> (set_w + 2);
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : btb_victim_sel
// Description : Picks the allocation way for one set: the lowest-numbered
//               invalid way, or the round-robin pointer when the set is full.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_victim_sel #(
    parameter int WAYS = 4,
    parameter int RR_W = 2
) (
    input  logic [WAYS-1:0] valid,
    input  logic [RR_W-1:0] rr,
    output logic [RR_W-1:0] way,
    output logic            all_valid
);

    // Scan from the top so the lowest invalid way is the last one written.
    always_comb begin
        way       = rr;
        all_valid = &valid;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                way = RR_W'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc
// Description : Set-associative branch target buffer with 2-bit confidence
//               counters, round-robin replacement and a one-set-per-cycle
//               flush engine. Define BTB_BYPASS_EN to forward a same-cycle
//               update to a matching lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_W  = BTB_ADDR_W,
    parameter int ENTRIES = 64,
    parameter int WAYS    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_req,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_taken,
    input  logic              flush_req,
    output logic              flush_busy
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - SET_W;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Table storage: valid/ctr/rr are reset, tag/target are not.
    logic [WAYS-1:0]   r_valid [SETS];
    logic [1:0]        r_ctr   [SETS][WAYS];
    logic [RR_W-1:0]   r_rr    [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [ADDR_W-1:0] r_tgt   [SETS][WAYS];

    flush_state_e      r_state;
    logic [SET_W-1:0]  r_flush_set;
    logic              r_pred_valid;
    logic [ADDR_W-1:0] r_pred_target;

    logic [SET_W-1:0]  w_lk_idx, w_upd_idx;
    logic [TAG_W-1:0]  w_lk_tag, w_upd_tag;
    logic              w_lk_hit, w_upd_hit;
    logic [1:0]        w_lk_ctr, w_upd_ctr;
    logic [ADDR_W-1:0] w_lk_tgt;
    logic [RR_W-1:0]   w_upd_way, w_victim;
    logic              w_all_valid;
    logic              w_upd_en;
    logic              w_nx_hit;
    logic [1:0]        w_nx_ctr;
    logic [ADDR_W-1:0] w_nx_tgt;
    logic              w_pred_fire;

    assign w_lk_idx  = SET_W'(btb_index(BTB_MAX_W'(pc_in), SET_W));
    assign w_lk_tag  = TAG_W'(btb_tag(BTB_MAX_W'(pc_in), SET_W));
    assign w_upd_idx = SET_W'(btb_index(BTB_MAX_W'(update_pc), SET_W));
    assign w_upd_tag = TAG_W'(btb_tag(BTB_MAX_W'(update_pc), SET_W));

    // Updates are dropped while flushing and in the cycle a flush is accepted.
    assign w_upd_en  = update_req && (r_state == IDLE) && !flush_req;

    // Lookup read: at most one way matches, so an OR-style scan is exact.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_ctr = 2'd0;
        w_lk_tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_ctr = r_ctr[w_lk_idx][w];
                w_lk_tgt = r_tgt[w_lk_idx][w];
            end
        end
    end

    // Update-side match against the resolved branch's set.
    always_comb begin
        w_upd_hit = 1'b0;
        w_upd_ctr = 2'd0;
        w_upd_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
                w_upd_hit = 1'b1;
                w_upd_ctr = r_ctr[w_upd_idx][w];
                w_upd_way = RR_W'(w);
            end
        end
    end

    btb_victim_sel #(
        .WAYS (WAYS),
        .RR_W (RR_W)
    ) u_victim_sel (
        .valid     (r_valid[w_upd_idx]),
        .rr        (r_rr[w_upd_idx]),
        .way       (w_victim),
        .all_valid (w_all_valid)
    );

    // Lookup result as seen by the output register, optionally post-update.
    always_comb begin
        w_nx_hit = w_lk_hit;
        w_nx_ctr = w_lk_ctr;
        w_nx_tgt = w_lk_tgt;
`ifdef BTB_BYPASS_EN
        if (w_upd_en && (w_lk_idx == w_upd_idx) && (w_lk_tag == w_upd_tag)) begin
            if (update_taken) begin
                w_nx_hit = 1'b1;
                w_nx_tgt = update_target;
                w_nx_ctr = w_upd_hit ? ctr_inc(w_upd_ctr) : CTR_INIT;
            end else if (w_upd_hit) begin
                w_nx_hit = (w_upd_ctr != 2'd0);
                w_nx_ctr = ctr_dec(w_upd_ctr);
            end
        end
`endif
    end

    assign w_pred_fire = fetch_valid && (r_state == IDLE) && w_nx_hit && w_nx_ctr[1];

    // Registered prediction; target forced to zero whenever no prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid  <= w_pred_fire;
            r_pred_target <= w_pred_fire ? w_nx_tgt : '0;
        end
    end

    // Flush FSM plus valid/ctr/rr training; flushing has priority over updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_set <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ctr[s][w] <= 2'd0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_state     <= FLUSH;
                        r_flush_set <= '0;
                    end else if (w_upd_en) begin
                        if (update_taken) begin
                            if (w_upd_hit) begin
                                r_ctr[w_upd_idx][w_upd_way] <= ctr_inc(w_upd_ctr);
                            end else begin
                                r_valid[w_upd_idx][w_victim] <= 1'b1;
                                r_ctr[w_upd_idx][w_victim]   <= CTR_INIT;
                                if (w_all_valid) begin
                                    r_rr[w_upd_idx] <= (r_rr[w_upd_idx] == RR_W'(WAYS - 1))
                                                       ? '0 : r_rr[w_upd_idx] + 1'b1;
                                end
                            end
                        end else if (w_upd_hit) begin
                            if (w_upd_ctr == 2'd0) begin
                                r_valid[w_upd_idx][w_upd_way] <= 1'b0;
                            end else begin
                                r_ctr[w_upd_idx][w_upd_way] <= ctr_dec(w_upd_ctr);
                            end
                        end
                    end
                end
                FLUSH: begin
                    r_valid[r_flush_set] <= '0;
                    r_rr[r_flush_set]    <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        r_ctr[r_flush_set][w] <= 2'd0;
                    end
                    if (r_flush_set == SET_W'(SETS - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_flush_set <= r_flush_set + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/target writes for taken updates (hit overwrite or new allocation).
    always_ff @(posedge clk) begin
        if (w_upd_en && update_taken) begin
            if (w_upd_hit) begin
                r_tgt[w_upd_idx][w_upd_way] <= update_target;
            end else begin
                r_tag[w_upd_idx][w_victim] <= w_upd_tag;
                r_tgt[w_upd_idx][w_victim] <= update_target;
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_target = r_pred_target;
    assign flush_busy  = (r_state == FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_assoc
// Description : Self-checking bench for btb_assoc (16 entries, 2 ways):
//               directed scenarios plus a randomized run against a
//               behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_assoc;

    localparam int AW = 32;
    localparam int NSETS = 8;
    localparam int NWAYS = 2;

    logic          clk;
    logic          rst_n;
    logic          fetch_valid;
    logic [AW-1:0] pc_in;
    logic          pred_valid;
    logic [AW-1:0] pred_target;
    logic          update_req;
    logic [AW-1:0] update_pc;
    logic [AW-1:0] update_target;
    logic          update_taken;
    logic          flush_req;
    logic          flush_busy;

    int n_vec = 0;
    int n_err = 0;

    btb_assoc #(.ADDR_W(AW), .ENTRIES(16), .WAYS(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid   (fetch_valid),
        .pc_in         (pc_in),
        .pred_valid    (pred_valid),
        .pred_target   (pred_target),
        .update_req    (update_req),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    bit          m_v   [NSETS][NWAYS];
    int unsigned m_tag [NSETS][NWAYS];
    int unsigned m_tgt [NSETS][NWAYS];
    int          m_ctr [NSETS][NWAYS];
    int          m_rr  [NSETS];
    int          m_busy;

    task automatic m_clear();
        for (int s = 0; s < NSETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NWAYS; w++) begin
                m_v[s][w] = 0;
                m_ctr[s][w] = 0;
            end
        end
    endtask

    task automatic m_lookup(input int unsigned pc, output bit hit, output int ctr,
                            output int unsigned tgt);
        int s;
        s = (pc / 4) % NSETS;
        hit = 0; ctr = 0; tgt = 0;
        for (int w = 0; w < NWAYS; w++)
            if (m_v[s][w] && m_tag[s][w] == pc / 32) begin
                hit = 1; ctr = m_ctr[s][w]; tgt = m_tgt[s][w];
            end
    endtask

    task automatic m_update(input int unsigned pc, input int unsigned tgt, input bit taken);
        int s, way, inv;
        s = (pc / 4) % NSETS;
        way = -1;
        for (int w = 0; w < NWAYS; w++)
            if (m_v[s][w] && m_tag[s][w] == pc / 32) way = w;
        if (taken) begin
            if (way >= 0) begin
                m_tgt[s][way] = tgt;
                if (m_ctr[s][way] < 3) m_ctr[s][way]++;
            end else begin
                inv = -1;
                for (int w = NWAYS - 1; w >= 0; w--) if (!m_v[s][w]) inv = w;
                if (inv < 0) begin
                    inv = m_rr[s];
                    m_rr[s] = (m_rr[s] + 1) % NWAYS;
                end
                m_v[s][inv] = 1; m_tag[s][inv] = pc / 32;
                m_tgt[s][inv] = tgt; m_ctr[s][inv] = 2;
            end
        end else if (way >= 0) begin
            if (m_ctr[s][way] == 0) m_v[s][way] = 0;
            else m_ctr[s][way]--;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; pc_in = '0; update_req = 0; update_pc = '0;
        update_target = '0; update_taken = 0; flush_req = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1;
        tick();
        m_clear();
        m_busy = 0;
    endtask

    task automatic lookup(input logic [AW-1:0] pc);
        fetch_valid = 1; pc_in = pc;
        tick();
        fetch_valid = 0;
    endtask

    task automatic upd(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk);
        update_req = 1; update_pc = pc; update_target = tgt; update_taken = tk;
        tick();
        update_req = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        n_vec++;
        if (pred_valid !== 1'b0 || pred_target !== '0 || flush_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got pv=%0b pt=%h busy=%0b, want 0/0/0", pred_valid, pred_target, flush_busy);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        lookup(32'h1000);
        n_vec++;
        if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
            n_err++;
            $display("FAIL reset_lookup: got pv=%0b pt=%h, want 0/0", pred_valid, pred_target);
        end
    endtask

    task automatic test_basic();
        upd(32'h1000, 32'h2000, 1);
        lookup(32'h1000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h2000) begin
            n_err++;
            $display("FAIL basic_hit: got pv=%0b pt=%h, want 1/2000", pred_valid, pred_target);
        end
        tick();
        n_vec++;
        if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
            n_err++;
            $display("FAIL no_fetch_low: got pv=%0b pt=%h, want 0/0", pred_valid, pred_target);
        end
        lookup(32'h1003);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h2000) begin
            n_err++;
            $display("FAIL low_bits_ignored: got pv=%0b pt=%h, want 1/2000", pred_valid, pred_target);
        end
        lookup(32'h3000);
        n_vec++;
        if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
            n_err++;
            $display("FAIL basic_miss: got pv=%0b pt=%h, want 0/0", pred_valid, pred_target);
        end
    endtask

    task automatic test_conflict();
        upd(32'h5000, 32'h6000, 1);
        lookup(32'h1000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h2000) begin
            n_err++;
            $display("FAIL conflict_keep_a: got pv=%0b pt=%h, want 1/2000", pred_valid, pred_target);
        end
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h6000) begin
            n_err++;
            $display("FAIL conflict_keep_b: got pv=%0b pt=%h, want 1/6000", pred_valid, pred_target);
        end
        upd(32'h9000, 32'hA000, 1);
        lookup(32'h1000);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++;
            $display("FAIL evict_way0: got pv=%0b, want 0", pred_valid);
        end
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h6000) begin
            n_err++;
            $display("FAIL evict_keep_way1: got pv=%0b pt=%h, want 1/6000", pred_valid, pred_target);
        end
        lookup(32'h9000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'hA000) begin
            n_err++;
            $display("FAIL evict_new: got pv=%0b pt=%h, want 1/a000", pred_valid, pred_target);
        end
    endtask

    task automatic test_confidence();
        upd(32'h5000, 32'h0, 0);
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ctr_2_to_1: got pv=%0b, want 0", pred_valid);
        end
        upd(32'h5000, 32'h0, 0);
        upd(32'h5000, 32'h0, 0);
        upd(32'h5000, 32'h6000, 1);
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h6000) begin
            n_err++;
            $display("FAIL realloc_after_clear: got pv=%0b pt=%h, want 1/6000", pred_valid, pred_target);
        end
        repeat (3) upd(32'h5000, 32'h6000, 1);
        upd(32'h5000, 32'h0, 0);
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h6000) begin
            n_err++;
            $display("FAIL ctr_saturate: got pv=%0b pt=%h, want 1/6000", pred_valid, pred_target);
        end
        upd(32'h5000, 32'h7000, 1);
        upd(32'hD000, 32'h0, 0);
        lookup(32'h5000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h7000) begin
            n_err++;
            $display("FAIL target_overwrite: got pv=%0b pt=%h, want 1/7000", pred_valid, pred_target);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        logic [AW-1:0] pcs [6];
        pcs = '{32'h5000, 32'h9000, 32'h1004, 32'h1008, 32'h101C, 32'h1010};
        upd(32'h1004, 32'h1111, 1);
        upd(32'h1008, 32'h2222, 1);
        upd(32'h101C, 32'h3333, 1);
        flush_req = 1;
        tick();
        flush_req = 0;
        busy_cycles = 0;
        while (flush_busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            fetch_valid = 1; pc_in = 32'h9000;
            update_req = 1; update_pc = 32'h1010; update_target = 32'h4444; update_taken = 1;
            flush_req = (busy_cycles == 3);
            tick();
            n_vec++;
            if (pred_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_lookup_blocked: cycle %0d got pv=%0b, want 0", busy_cycles, pred_valid);
            end
        end
        idle_inputs();
        n_vec++;
        if (busy_cycles != NSETS) begin
            n_err++;
            $display("FAIL flush_length: got %0d busy cycles, want %0d", busy_cycles, NSETS);
        end
        for (int i = 0; i < 6; i++) begin
            lookup(pcs[i]);
            n_vec++;
            if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
                n_err++;
                $display("FAIL after_flush_miss: pc=%h got pv=%0b pt=%h, want 0/0", pcs[i], pred_valid, pred_target);
            end
        end
    endtask

    task automatic test_midflush_reset();
        upd(32'h101C, 32'h3333, 1);
        flush_req = 1;
        tick();
        flush_req = 0;
        repeat (2) tick();
        rst_n = 0;
        #1;
        n_vec++;
        if (flush_busy !== 1'b0 || pred_valid !== 1'b0 || pred_target !== '0) begin
            n_err++;
            $display("FAIL midflush_reset: got busy=%0b pv=%0b pt=%h, want 0/0/0", flush_busy, pred_valid, pred_target);
        end
        tick();
        @(negedge clk);
        rst_n = 1;
        tick();
        lookup(32'h101C);
        n_vec++;
        if (pred_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_miss: got pv=%0b, want 0", pred_valid);
        end
        upd(32'h1000, 32'h2000, 1);
        lookup(32'h1000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h2000) begin
            n_err++;
            $display("FAIL post_reset_hit: got pv=%0b pt=%h, want 1/2000", pred_valid, pred_target);
        end
    endtask

    task automatic test_same_cycle();
        logic          exp_pv;
        logic [AW-1:0] exp_pt;
`ifdef BTB_BYPASS_EN
        exp_pv = 1'b1; exp_pt = 32'hB000;
`else
        exp_pv = 1'b0; exp_pt = 32'h0;
`endif
        fetch_valid = 1; pc_in = 32'hA000;
        update_req = 1; update_pc = 32'hA000; update_target = 32'hB000; update_taken = 1;
        tick();
        idle_inputs();
        n_vec++;
        if (pred_valid !== exp_pv || pred_target !== exp_pt) begin
            n_err++;
            $display("FAIL same_cycle: got pv=%0b pt=%h, want %0b/%h", pred_valid, pred_target, exp_pv, exp_pt);
        end
        lookup(32'hA000);
        n_vec++;
        if (pred_valid !== 1'b1 || pred_target !== 32'hB000) begin
            n_err++;
            $display("FAIL same_cycle_next: got pv=%0b pt=%h, want 1/b000", pred_valid, pred_target);
        end
    endtask

    function automatic int unsigned rand_pc();
        return ($urandom_range(128, 130) * 32) + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        bit          fv, uv, tk, fr, acc, done, hit, e_pv;
        int unsigned lpc, upc, utgt, tgt, e_pt;
        int          ctr;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            fv = ($urandom_range(0, 3) != 0);
            lpc = rand_pc();
            uv = ($urandom_range(0, 2) != 0);
            upc = ($urandom_range(0, 3) == 0) ? lpc : rand_pc();
            utgt = $urandom;
            tk = ($urandom_range(0, 3) != 0);
            fr = ($urandom_range(0, 79) == 0);
            fetch_valid = fv; pc_in = lpc;
            update_req = uv; update_pc = upc; update_target = utgt; update_taken = tk;
            flush_req = fr;
            acc = (m_busy == 0) && uv && !fr;
            done = 0;
`ifdef BTB_BYPASS_EN
            if (acc && (lpc / 4) == (upc / 4)) begin
                m_update(upc, utgt, tk);
                done = 1;
            end
`endif
            e_pv = 0; e_pt = 0;
            if (fv && m_busy == 0) begin
                m_lookup(lpc, hit, ctr, tgt);
                if (hit && ctr >= 2) begin
                    e_pv = 1; e_pt = tgt;
                end
            end
            if (acc && !done) m_update(upc, utgt, tk);
            if (m_busy > 0) m_busy--;
            else if (fr) begin
                m_clear();
                m_busy = NSETS;
            end
            tick();
            n_vec++;
            if (pred_valid !== e_pv || pred_target !== e_pt || flush_busy !== (m_busy != 0)) begin
                n_err++;
                $display("FAIL random[%0d]: got pv=%0b pt=%h busy=%0b, want %0b/%h/%0b",
                         c, pred_valid, pred_target, flush_busy, e_pv, e_pt, (m_busy != 0));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        m_busy = 0;
        #2;
        test_reset();
        test_basic();
        test_conflict();
        test_confidence();
        test_flush();
        test_midflush_reset();
        test_same_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage, successor to the direct-mapped 16-entry BTB. On each valid fetch it returns a registered target prediction one cycle later. Updates come from branch resolution and train a per-entry 2-bit confidence counter, with round-robin replacement within a set. A multi-cycle flush engine invalidates the whole table without asserting reset.

## Interface
- ADDR_W, 32, PC/target width
- ENTRIES, 64, total entries; power of two
- WAYS, 4, associativity; power of two, 1..ENTRIES
- Derived, not overridable:
  - SETS = ENTRIES/WAYS
  - SET_W = log2(SETS)
  - TAG_W = ADDR_W-2-SET_W
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  lookup request this cycle
- pc_in  in  ADDR_W  lookup PC
- pred_valid  out  1  registered: hit with confident counter
- pred_target  out  ADDR_W  registered predicted target; 0 when pred_valid=0
- update_req  in  1  resolution update this cycle
- update_pc  in  ADDR_W  resolved branch PC
- update_target  in  ADDR_W  resolved target
- update_taken  in  1  resolved direction
- flush_req  in  1  pulse: start full invalidate
- flush_busy  out  1  flush in progress

## Operation
- Index = pc[SET_W+1:2]. Tag = pc[ADDR_W-1:SET_W+2]. pc[1:0] is ignored.
- Per entry: valid, tag, target, ctr[1:0]. Per set: round-robin victim pointer rr[log2(WAYS)-1:0].
- Lookup:
  - Hit = valid and tag match in any way of the set. At most one way can match (update guarantees this).
  - pred_valid = fetch_valid & hit & ctr[1].
  - pred_target = that way's target, otherwise 0.
- Update, taken, hit: target overwritten; ctr saturating-increment to 3.
- Update, taken, miss: allocate into the lowest-numbered invalid way. If none is invalid, allocate into way rr and advance rr by 1 (mod WAYS). New entry gets valid=1, tag, target, ctr=2.
- Update, not-taken, hit: ctr saturating-decrement; if ctr was 0, clear valid. Target is unchanged.
- Update, not-taken, miss: no change.
- Flush FSM:
  - IDLE→FLUSH when flush_req=1. The set counter starts at 0.
  - FLUSH clears valid and ctr for one set per cycle, and resets that set's rr to 0.
  - FLUSH→IDLE after set SETS-1 is cleared.
  - flush_busy=1 exactly while in FLUSH.
- During FLUSH: lookups return pred_valid=0; update_req is dropped; flush_req is ignored.
- An update in the same cycle flush_req is accepted in IDLE is dropped.

## Timing
- Reset values:
  - pred_valid=0, pred_target=0, flush_busy=0, FSM=IDLE.
  - All valid, ctr and rr = 0. Tag and target arrays need no reset.
- Lookup latency is 1 cycle: request at edge N, result valid after edge N+1. pred_* is held low in any cycle following fetch_valid=0.
- Updates commit at the clock edge where update_req=1 and are visible to lookups issued in the next cycle.
- A same-cycle lookup and update to the same set sees pre-update contents, unless bypass is compiled in.
- Flush takes exactly SETS cycles: flush_busy rises the edge after flush_req and falls after SETS edges. The first lookup after flush_busy falls misses.
- rst_n asserted mid-flush aborts to IDLE immediately; all outputs go to their reset values asynchronously.

## Configuration
- BTB_BYPASS_EN defined:
  - A lookup whose PC index and tag equal an update in the same cycle returns the post-update state.
  - New or updated target and ctr are forwarded combinationally into the output register.
- Not defined: no forwarding; the lookup sees old contents.

## Structure
- Shared package btb_pkg holds:
  - ADDR_W default
  - helpers for index and tag extraction
  - ctr encoding constants CTR_INIT=2, CTR_MAX=3
  - flush FSM state enum {IDLE, FLUSH}
- One natural sub-module: btb_victim_sel.
  - Inputs: a set's valid vector and rr.
  - Output: the way to allocate, as a priority-invalid/round-robin pick.
- Storage is flop arrays (all valid bits need asynchronous reset).

## Test plan
All scenarios use ENTRIES=16, WAYS=2 (8 sets, index pc[4:2]).
- Out of reset: lookup 0x1000 → pred_valid=0, pred_target=0.
- Taken update 0x1000→0x2000, then lookup 0x1000 next cycle → pred_valid=1, target 0x2000. Lookup 0x3000 → miss.
- Conflict retention:
  - Taken update 0x5000→0x6000 (same set as 0x1000).
  - Lookups of 0x1000 and 0x5000 both hit, returning 0x2000 and 0x6000.
  - Taken update 0x9000→0xA000 evicts way 0 (0x1000). The 0x1000 lookup misses; 0x5000 still hits.
- Confidence training:
  - Not-taken update 0x5000 drops ctr 2→1; lookup 0x5000 → pred_valid=0.
  - A second not-taken drops ctr 1→0; a third clears valid.
  - A taken update re-allocates the entry with ctr=2 → hit.
- Flush: fill several sets, pulse flush_req → flush_busy high for exactly 8 cycles. Updates issued during busy are dropped. Every lookup afterwards misses.
- Mid-flush reset: drop rst_n at flush cycle 3 → flush_busy=0 and pred_valid=0 immediately; after release, lookups miss and a new update/lookup pair works.
- Same-cycle lookup and update of 0xA000: with BTB_BYPASS_EN the result is a hit with the new target; without it the result is a miss.
